// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter: free-running BCLK/LRCLK divider, one-deep sample holding register,
// frame load on bit_cnt wrap, outputs change only on BCLK falling edges; underrun/overrun counted.
module audio_i2s_tx #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_ce,
  input  logic [15:0] in_l,
  input  logic [15:0] in_r,
  input  logic        mute,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic [7:0]  underrun_cnt,
  output logic [7:0]  overrun_cnt
);

  localparam int BW = $clog2(2 * SLOT_BITS);

  localparam logic [7:0]    DIV_LAST = 8'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);
  localparam logic [BW-1:0] LR_FIRST = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] LR_LAST  = BW'(2 * SLOT_BITS - 2);
  localparam logic [BW-1:0] DATA_W   = BW'(16);

  logic [7:0]    div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [15:0]   hold_l, hold_r;
  logic [15:0]   shift_l, shift_r;
  logic          pending;

  logic          fall;
  logic          load;
  logic [BW-1:0] bit_nxt;
  logic [BW-1:0] r_off;
  logic [15:0]   shl_nxt, shr_nxt;
  logic          sdata_nxt;
  logic          lr_nxt;

  always_comb begin
    fall    = i2s_bclk && (div_cnt == DIV_LAST);
    bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    load    = fall && (bit_nxt == '0);

    shl_nxt = shift_l;
    shr_nxt = shift_r;
    if (load) begin
      shl_nxt = mute ? 16'h0000 : hold_l;
      shr_nxt = mute ? 16'h0000 : hold_r;
    end

    // Drive reflects the bit_cnt value being entered, so a freshly loaded word shows its MSB at once.
    r_off     = bit_nxt - SLOT;
    sdata_nxt = 1'b0;
    if (bit_nxt < DATA_W) begin
      sdata_nxt = shl_nxt[4'd15 - bit_nxt[3:0]];
    end else if ((bit_nxt >= SLOT) && (r_off < DATA_W)) begin
      sdata_nxt = shr_nxt[4'd15 - r_off[3:0]];
    end

    // Word select leads each channel's MSB by one BCLK.
    lr_nxt = (bit_nxt >= LR_FIRST) && (bit_nxt <= LR_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      i2s_bclk     <= 1'b0;
      i2s_lrclk    <= 1'b0;
      i2s_sdata    <= 1'b0;
      bit_cnt      <= '0;
      shift_l      <= '0;
      shift_r      <= '0;
      hold_l       <= '0;
      hold_r       <= '0;
      pending      <= 1'b0;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end

      if (fall) begin
        bit_cnt   <= bit_nxt;
        shift_l   <= shl_nxt;
        shift_r   <= shr_nxt;
        i2s_sdata <= sdata_nxt;
        i2s_lrclk <= lr_nxt;
      end

      if (load && !pending && (underrun_cnt != 8'hFF)) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end

      // A strobe coinciding with a load queues behind it rather than overwriting.
      if (sample_ce) begin
        hold_l  <= in_l;
        hold_r  <= in_r;
        pending <= 1'b1;
        if (pending && !load && (overrun_cnt != 8'hFF)) begin
          overrun_cnt <= overrun_cnt + 8'd1;
        end
      end else if (load) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
